dct_quant_zigzag: RTL and testbench
===================================

DCT_QUANT_ZIGZAG -- requirements
Module: dct_quant_zigzag

Interface
REQ-001 SHALL have parameters: IN_WIDTH, default 12, signed DCT coefficient width; OUT_WIDTH, default 12, signed quantized output width.
REQ-002 SHALL have one clock and an asynchronous active-low reset: clk  input  1  rising-edge clock for all state.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 in_data  input  IN_WIDTH  signed DCT coefficient, raster order (r = row*8+col) within an 8x8 block.
REQ-005 in_valid  input  1  in_data valid this cycle; no backpressure is offered upstream.
REQ-006 out_data  output  OUT_WIDTH  signed quantized coefficient, zigzag order.
REQ-007 out_index  output  6  zigzag position k (0..63) of out_data.
REQ-008 out_last  output  1  high with k=63.
REQ-009 out_valid  output  1  out_data/out_index/out_last valid.
REQ-010 out_ready  input  1  consumer accepts; a transfer occurs when out_valid && out_ready.
REQ-011 overflow  output  1  sticky; an input was dropped.

Function
REQ-012 SHALL buffer input in two 64-entry ping-pong banks; each bank is EMPTY -> FILLING -> FULL -> DRAINING -> EMPTY.
REQ-013 Write side: each in_valid writes bank[wr_bank][wr_cnt] and increments a 6-bit wr_cnt; at wr_cnt=63 the bank becomes FULL, wr_cnt wraps to 0, and wr_bank toggles.
REQ-014 An in_valid while the target bank is FULL or DRAINING SHALL be dropped, SHALL set overflow, and SHALL NOT advance wr_cnt.
REQ-015 Read side: the oldest FULL bank enters DRAINING and is read at raster address zz[k] for k=0..63. The zz table is the standard JPEG zigzag (zz[0..5] = 0,1,8,16,9,2; zz[63] = 63).
REQ-016 Read pipeline: address register -> RAM read/quantize register -> output register.
  - out_valid SHALL assert on the 2nd rising edge after the edge that samples the 64th coefficient, when the read side is idle.
REQ-017 While out_valid && !out_ready, out_data, out_index and out_last SHALL hold stable.
  - No output SHALL be skipped or duplicated.
REQ-018 When k=63 transfers, the bank SHALL return to EMPTY.
  - If the other bank is FULL on the same cycle, its k=0 SHALL follow on the next cycle with no bubble.
REQ-019 If the write side fills a bank on the same cycle the read side frees the other, both transitions SHALL take effect.
REQ-020 Quantization (when enabled):
  - recip[r] = round(65536/Q[r]), where Q is the JPEG Annex K luminance table (Q[0]=16, so recip[0]=4096).
  - For v >= 0: q = (v*recip + 32768) >> 16.
  - For v < 0: q = -((-v*recip + 32768) >> 16), i.e. round half away from zero.
REQ-021 The result SHALL saturate to the signed OUT_WIDTH range.

Reset
REQ-022 On rst_n low, asynchronously: both banks EMPTY, wr_cnt=0, wr_bank=0, out_valid=0, out_data=0, out_index=0, out_last=0, overflow=0.
  - Bank RAM contents need not be reset.
REQ-023 Reset mid-block or mid-drain SHALL discard all buffered data.
  - The first in_valid after release is raster index 0 of a new block.

Configuration
REQ-024 Macro DCT_QUANT_ZIGZAG_QUANT_EN, when defined, SHALL compile in the reciprocal ROM and multiplier per REQ-020.
REQ-025 Without DCT_QUANT_ZIGZAG_QUANT_EN, out_data SHALL be in_data reordered only, saturated to OUT_WIDTH.
  - Latency and handshake SHALL be identical to the enabled build.

Verification
REQ-026 The bench SHALL cover: quant off, one block in_data=r, out_ready=1 -> out_data 0,1,8,16,9,2,... with out_index 0..63, out_last at k=63, first out_valid 2 cycles after the 64th input.
REQ-027 The bench SHALL cover: quant on, in_data[0]=16 -> out 1; in_data[0]=-8 -> out -1; in_data[0]=7 -> out 0.
REQ-028 The bench SHALL cover: out_ready low for 5 cycles at k=10 -> outputs held at k=10, sequence resumes at k=10 with no loss.
REQ-029 The bench SHALL cover: three back-to-back blocks with out_ready=0 -> overflow rises on the 1st sample of block 3; blocks 1 and 2 drain intact once out_ready=1.
REQ-030 The bench SHALL cover: two back-to-back blocks with out_ready=1 -> 128 consecutive transfers with no bubble between k=63 and the next k=0.
REQ-031 The bench SHALL cover: rst_n pulsed low mid-drain at k=30 -> outputs at reset values immediately; the next full block drains from k=0.

Source files
------------

// File: rtl/dct_quant_zigzag.sv
// DCT coefficient quantizer + zigzag reorder with a 2x64 ping-pong buffer.
// Latency: first out_valid on the 2nd clk edge after the edge taking the 64th input (read side idle).
// Backpressure: out_ready stalls the 3-stage read pipe; inputs are never stalled, they are dropped (overflow) when no bank is free.
// Optional quantizer compiled in with `define DCT_QUANT_ZIGZAG_QUANT_EN (JPEG Annex K luminance table).
module dct_quant_zigzag #(
    parameter int IN_WIDTH  = 12,
    parameter int OUT_WIDTH = 12
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [IN_WIDTH-1:0]  in_data,
    input  logic                 in_valid,
    output logic [OUT_WIDTH-1:0] out_data,
    output logic [5:0]           out_index,
    output logic                 out_last,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 overflow
);

    // Wide signed result before saturation; must exceed OUT_WIDTH.
    localparam int WW = IN_WIDTH + 16;

    // Zigzag position k -> raster address.
    localparam int ZZ [64] = '{
         0,  1,  8, 16,  9,  2,  3, 10,
        17, 24, 32, 25, 18, 11,  4,  5,
        12, 19, 26, 33, 40, 48, 41, 34,
        27, 20, 13,  6,  7, 14, 21, 28,
        35, 42, 49, 56, 57, 50, 43, 36,
        29, 22, 15, 23, 30, 37, 44, 51,
        58, 59, 52, 45, 38, 31, 39, 46,
        53, 60, 61, 54, 47, 55, 62, 63
    };

    typedef enum logic [1:0] {
        B_EMPTY,
        B_FILLING,
        B_FULL,
        B_DRAINING
    } bank_st_e;

    bank_st_e bank_st  [2];
    bank_st_e bank_nxt [2];

    logic                 wr_bank;
    logic [5:0]           wr_cnt;
    logic                 rd_bank;
    logic [IN_WIDTH-1:0]  mem [128];

    // Read pipeline: s0 = address, s1 = RAM read + quantize, out = output register.
    logic                 s0_vld;
    logic [5:0]           s0_k;
    logic                 s0_bank;
    logic                 s1_vld;
    logic [5:0]           s1_k;
    logic                 s1_bank;
    logic [OUT_WIDTH-1:0] s1_dat;
    logic                 out_bank;

    logic                 wr_ok;
    logic                 wr_fire;
    logic                 wr_done;
    logic                 out_adv;
    logic                 s1_adv;
    logic                 s0_free;
    logic                 rd_full;
    logic                 rd_start;
    logic                 xfer_last;
    logic [5:0]           rd_addr;
    logic [IN_WIDTH-1:0]  rd_raw;
    logic signed [WW-1:0] wide;
    logic [OUT_WIDTH-1:0] sat_dat;

    // Handshake and pipeline-advance terms.
    always_comb begin
        wr_ok     = (bank_st[wr_bank] == B_EMPTY) || (bank_st[wr_bank] == B_FILLING);
        wr_fire   = in_valid && wr_ok;
        wr_done   = wr_fire && (wr_cnt == 6'd63);
        out_adv   = !out_valid || out_ready;
        s1_adv    = !s1_vld || out_adv;
        s0_free   = !s0_vld || (s1_adv && (s0_k == 6'd63));
        // A bank completing this very cycle may start draining immediately.
        rd_full   = (bank_st[rd_bank] == B_FULL) || (wr_done && (wr_bank == rd_bank));
        rd_start  = s0_free && rd_full;
        xfer_last = out_valid && out_ready && out_last;
        rd_addr   = 6'(ZZ[s0_k]);
        rd_raw    = mem[{s0_bank, rd_addr}];
    end

    // Bank lifecycle next state; write, drain start and drain end may hit different banks together.
    always_comb begin
        for (int b = 0; b < 2; b++) begin
            bank_nxt[b] = bank_st[b];
            if (wr_fire && (wr_bank == b[0]))
                bank_nxt[b] = (wr_cnt == 6'd63) ? B_FULL : B_FILLING;
            if (rd_start && (rd_bank == b[0]))
                bank_nxt[b] = B_DRAINING;
            if (xfer_last && (out_bank == b[0]))
                bank_nxt[b] = B_EMPTY;
        end
    end

    // Bank state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bank_st[0] <= B_EMPTY;
            bank_st[1] <= B_EMPTY;
        end else begin
            bank_st[0] <= bank_nxt[0];
            bank_st[1] <= bank_nxt[1];
        end
    end

    // Write pointer and sticky drop flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_cnt   <= 6'd0;
            wr_bank  <= 1'b0;
            overflow <= 1'b0;
        end else begin
            if (wr_fire) begin
                wr_cnt <= wr_cnt + 6'd1;
                if (wr_cnt == 6'd63)
                    wr_bank <= ~wr_bank;
            end
            if (in_valid && !wr_ok)
                overflow <= 1'b1;
        end
    end

    // Coefficient storage; contents are don't-care after reset.
    always_ff @(posedge clk) begin
        if (wr_fire)
            mem[{wr_bank, wr_cnt}] <= in_data;
    end

`ifdef DCT_QUANT_ZIGZAG_QUANT_EN
    localparam int PW = IN_WIDTH + 15;

    // round(65536 / Q[r]) for the luminance table, raster order.
    localparam int RECIP [64] = '{
        4096, 5958, 6554, 4096, 2731, 1638, 1285, 1074,
        5461, 5461, 4681, 3449, 2521, 1130, 1092, 1192,
        4681, 5041, 4096, 2731, 1638, 1150,  950, 1170,
        4681, 3855, 2979, 2260, 1285,  753,  819, 1057,
        3641, 2979, 1771, 1170,  964,  601,  636,  851,
        2731, 1872, 1192, 1024,  809,  630,  580,  712,
        1337, 1024,  840,  753,  636,  542,  546,  649,
         910,  712,  690,  669,  585,  655,  636,  662
    };

    logic                rd_neg;
    logic [IN_WIDTH:0]   rd_ext;
    logic [IN_WIDTH:0]   rd_mag;
    logic [PW-1:0]       prod;
    logic [PW-1:0]       qmag;

    // Sign-magnitude multiply so rounding is half away from zero.
    always_comb begin
        rd_neg = rd_raw[IN_WIDTH-1];
        rd_ext = {rd_raw[IN_WIDTH-1], rd_raw};
        rd_mag = rd_neg ? -rd_ext : rd_ext;
        prod   = PW'(rd_mag) * PW'(RECIP[rd_addr]) + PW'(32'd32768);
        qmag   = prod >> 16;
        wide   = rd_neg ? -$signed({1'b0, qmag}) : $signed({1'b0, qmag});
    end
`else
    // Pass-through: sign-extend only.
    always_comb begin
        wide = {{(WW-IN_WIDTH){rd_raw[IN_WIDTH-1]}}, rd_raw};
    end
`endif

    // Saturate to the signed output range.
    always_comb begin
        if ((&wide[WW-1:OUT_WIDTH-1]) || !(|wide[WW-1:OUT_WIDTH-1]))
            sat_dat = wide[OUT_WIDTH-1:0];
        else if (wide[WW-1])
            sat_dat = {1'b1, {(OUT_WIDTH-1){1'b0}}};
        else
            sat_dat = {1'b0, {(OUT_WIDTH-1){1'b1}}};
    end

    // Address stage: walks k=0..63 of the draining bank, chains into the next full bank without a gap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s0_vld  <= 1'b0;
            s0_k    <= 6'd0;
            s0_bank <= 1'b0;
            rd_bank <= 1'b0;
        end else if (rd_start) begin
            s0_vld  <= 1'b1;
            s0_k    <= 6'd0;
            s0_bank <= rd_bank;
            rd_bank <= ~rd_bank;
        end else if (s0_vld && s1_adv) begin
            if (s0_k == 6'd63)
                s0_vld <= 1'b0;
            else
                s0_k <= s0_k + 6'd1;
        end
    end

    // Read/quantize register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_vld  <= 1'b0;
            s1_k    <= 6'd0;
            s1_bank <= 1'b0;
            s1_dat  <= '0;
        end else if (s1_adv) begin
            s1_vld  <= s0_vld;
            s1_k    <= s0_k;
            s1_bank <= s0_bank;
            s1_dat  <= sat_dat;
        end
    end

    // Output register; holds while stalled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_index <= 6'd0;
            out_last  <= 1'b0;
            out_bank  <= 1'b0;
        end else if (out_adv) begin
            out_valid <= s1_vld;
            if (s1_vld) begin
                out_data  <= s1_dat;
                out_index <= s1_k;
                out_last  <= (s1_k == 6'd63);
                out_bank  <= s1_bank;
            end
        end
    end

endmodule

// File: tb/tb_dct_quant_zigzag.sv
// Directed bench for dct_quant_zigzag: reorder, quantize spot values, stall, overflow, back-to-back, reset.
// Input width is widened so that, in the quantized build, inputs Q[r]*m come out exactly as m.
module tb_dct_quant_zigzag;

    localparam int IW = 16;
    localparam int OW = 12;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [IW-1:0] in_data;
    logic          in_valid;
    logic [OW-1:0] out_data;
    logic [5:0]    out_index;
    logic          out_last;
    logic          out_valid;
    logic          out_ready;
    logic          overflow;

    always #5 clk = ~clk;

    dct_quant_zigzag #(.IN_WIDTH(IW), .OUT_WIDTH(OW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .out_data  (out_data),
        .out_index (out_index),
        .out_last  (out_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .overflow  (overflow)
    );

    int ZZ [64] = '{
         0,  1,  8, 16,  9,  2,  3, 10,
        17, 24, 32, 25, 18, 11,  4,  5,
        12, 19, 26, 33, 40, 48, 41, 34,
        27, 20, 13,  6,  7, 14, 21, 28,
        35, 42, 49, 56, 57, 50, 43, 36,
        29, 22, 15, 23, 30, 37, 44, 51,
        58, 59, 52, 45, 38, 31, 39, 46,
        53, 60, 61, 54, 47, 55, 62, 63
    };

`ifdef DCT_QUANT_ZIGZAG_QUANT_EN
    // JPEG Annex K luminance quantizer, raster order.
    int QT [64] = '{
        16, 11, 10, 16,  24,  40,  51,  61,
        12, 12, 14, 19,  26,  58,  60,  55,
        14, 13, 16, 24,  40,  57,  69,  56,
        14, 17, 22, 29,  51,  87,  80,  62,
        18, 22, 37, 56,  68, 109, 103,  77,
        24, 35, 55, 64,  81, 104, 113,  92,
        49, 64, 78, 87, 103, 121, 120, 101,
        72, 92, 95, 98, 112, 100, 103,  99
    };
    int E0 [3] = '{1, -1, 0};
`else
    // Unit scale: pass-through build.
    int QT [64] = '{default: 1};
    int E0 [3] = '{16, -8, 7};
`endif
    int E5 [3] = '{2047, -2048, 0};
    int S0 [3] = '{16, -8, 7};
    int S2 [3] = '{30000, -30000, 0};

    typedef struct {
        int idx;
        int dat;
        int last;
        int cyc;
    } xfer_t;

    xfer_t q [$];
    int    rawv [64];
    int    n_checks = 0;
    int    n_pass   = 0;
    int    cyc      = 0;

    always @(posedge clk) cyc = cyc + 1;

    // Record every completed transfer with its cycle stamp.
    always @(negedge clk) begin
        xfer_t x;
        if (rst_n && out_valid && out_ready) begin
            x.idx  = int'(out_index);
            x.dat  = int'($signed(out_data));
            x.last = int'(out_last);
            x.cyc  = cyc;
            q.push_back(x);
        end
    end

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got == exp)
            n_pass++;
        else
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic fill_pat(input int base);
        for (int r = 0; r < 64; r++)
            rawv[r] = QT[r] * (base + r);
    endtask

    task automatic send_blk();
        for (int r = 0; r < 64; r++) begin
            @(posedge clk); #1;
            in_valid = 1'b1;
            in_data  = IW'(rawv[r]);
        end
    endtask

    task automatic go_idle();
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_xfers(input string tag, input int n);
        int w;
        w = 0;
        while (q.size() < n && w < 1000) begin
            @(posedge clk);
            w++;
        end
        #1;
        check({tag, "_count"}, q.size(), n);
    endtask

    task automatic check_seq(input string tag, input int first, input int base, input bit contig);
        for (int k = 0; k < 64; k++) begin
            int i;
            i = first + k;
            if (i < q.size()) begin
                check($sformatf("%s_idx%0d", tag, k), q[i].idx, k);
                check($sformatf("%s_dat%0d", tag, k), q[i].dat, base + ZZ[k]);
                check($sformatf("%s_last%0d", tag, k), q[i].last, (k == 63) ? 1 : 0);
                if (contig && i > 0)
                    check($sformatf("%s_gap%0d", tag, k), q[i].cyc - q[i-1].cyc, 1);
            end
        end
    endtask

    task automatic wait_index(input int k, output bit found);
        found = 1'b0;
        for (int w = 0; w < 300 && !found; w++) begin
            @(posedge clk); #1;
            if (out_valid && int'(out_index) == k)
                found = 1'b1;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit found;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_valid", int'(out_valid), 0);
        check("rst_data",  int'(out_data),  0);
        check("rst_index", int'(out_index), 0);
        check("rst_last",  int'(out_last),  0);
        check("rst_ovf",   int'(overflow),  0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("post_rst_valid", int'(out_valid), 0);

        // One block, raster ramp, free-running consumer: latency and zigzag order.
        q.delete();
        fill_pat(0);
        send_blk();
        go_idle();
        check("lat_e0", int'(out_valid), 0);
        @(posedge clk); #1;
        check("lat_e1", int'(out_valid), 0);
        @(posedge clk); #1;
        check("lat_e2", int'(out_valid), 1);
        check("lat_e2_idx", int'(out_index), 0);
        wait_xfers("t1", 64);
        check_seq("t1", 0, 0, 1'b1);

        // Spot values at r=0 (k=0) and r=2 (k=5), including saturation.
        for (int b = 0; b < 3; b++) begin
            q.delete();
            for (int r = 0; r < 64; r++) rawv[r] = 0;
            rawv[0] = S0[b];
            rawv[2] = S2[b];
            send_blk();
            go_idle();
            wait_xfers($sformatf("spot%0d", b), 64);
            if (q.size() > 5) begin
                check($sformatf("spot%0d_k0", b), q[0].dat, E0[b]);
                check($sformatf("spot%0d_k5", b), q[5].dat, E5[b]);
            end
        end

        // Consumer stalls for 5 cycles while k=10 is presented.
        q.delete();
        fill_pat(0);
        send_blk();
        go_idle();
        wait_index(10, found);
        check("stall_found", int'(found), 1);
        out_ready = 1'b0;
        repeat (5) begin
            @(posedge clk); #1;
            check("hold_valid", int'(out_valid), 1);
            check("hold_idx", int'(out_index), 10);
            check("hold_dat", int'($signed(out_data)), ZZ[10]);
        end
        out_ready = 1'b1;
        wait_xfers("t2", 64);
        check_seq("t2", 0, 0, 1'b0);

        // Two back-to-back blocks: 128 transfers, no bubble across the bank switch.
        q.delete();
        fill_pat(0);
        send_blk();
        fill_pat(64);
        send_blk();
        go_idle();
        wait_xfers("t4", 128);
        check_seq("t4a", 0, 0, 1'b1);
        check_seq("t4b", 64, 64, 1'b1);

        // Three blocks against a stalled consumer: the third is dropped.
        q.delete();
        out_ready = 1'b0;
        fill_pat(0);
        send_blk();
        fill_pat(64);
        send_blk();
        @(posedge clk); #1;
        check("ovf_pre", int'(overflow), 0);
        in_valid = 1'b1;
        in_data  = IW'(5);
        @(posedge clk); #1;
        check("ovf_set", int'(overflow), 1);
        repeat (63) @(posedge clk);
        #1;
        in_valid = 1'b0;
        check("stalled_no_xfer", q.size(), 0);
        out_ready = 1'b1;
        wait_xfers("t3", 128);
        check_seq("t3a", 0, 0, 1'b1);
        check_seq("t3b", 64, 64, 1'b1);
        repeat (10) @(posedge clk);
        #1;
        check("blk3_dropped_cnt", q.size(), 128);
        check("blk3_dropped_vld", int'(out_valid), 0);
        check("ovf_sticky", int'(overflow), 1);

        // Reset pulse mid-drain at k=30, then a fresh block.
        q.delete();
        fill_pat(0);
        send_blk();
        go_idle();
        wait_index(30, found);
        check("k30_found", int'(found), 1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_valid", int'(out_valid), 0);
        check("mid_rst_data",  int'(out_data),  0);
        check("mid_rst_index", int'(out_index), 0);
        check("mid_rst_last",  int'(out_last),  0);
        check("mid_rst_ovf",   int'(overflow),  0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        q.delete();
        fill_pat(64);
        send_blk();
        go_idle();
        wait_xfers("t5", 64);
        check_seq("t5", 0, 64, 1'b1);
        repeat (5) @(posedge clk);
        #1;
        check("t5_no_extra", q.size(), 64);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
